gb_cpu_ir_control: RTL

GB_CPU_IR_CONTROL -- requirements
Module: gb_cpu_ir_control

---
 rtl/gb_cpu_common_pkg.sv | 20 ++
 rtl/gb_cpu_ir_control_if.sv | 31 +++
 rtl/gb_cpu_ime_ctrl.sv | 51 +++++
 rtl/gb_cpu_ir_control.sv | 122 ++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU instruction-register front end.
// Holds the fetch FSM state type, the CB prefix byte and the interrupt-pending helper.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        CB_FETCH = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } ir_state_t;

    localparam logic [7:0] CB_PREFIX_OPCODE = 8'hCB;
    localparam logic [7:0] NOP_OPCODE       = 8'h00;

    // An interrupt is requested when any enabled source has its flag raised.
    function automatic logic irq_requested(input logic [4:0] ie_bits, input logic [4:0] if_bits);
        return |(ie_bits & if_bits);
    endfunction

endpackage

// File: rtl/gb_cpu_ir_control_if.sv
// Bus between the sequencer/memory side and the instruction-register controller.
// master drives the M-cycle strobe, fetched byte and instruction requests; slave is the controller.
interface gb_cpu_ir_control_if;
    logic       m_tick;
    logic [7:0] mem_rdata;
    logic       instr_done;
    logic [4:0] ie;
    logic [4:0] if_flags;
    logic       halt_req;
    logic       ei_req;
    logic       di_req;
    logic       reti_req;
    logic [7:0] opcode;
    logic       cb_prefix;
    logic       isr_cmd;
    logic       pc_inc;
    logic       ime;
    logic       halted;

    modport master (
        output m_tick, mem_rdata, instr_done, ie, if_flags,
        output halt_req, ei_req, di_req, reti_req,
        input  opcode, cb_prefix, isr_cmd, pc_inc, ime, halted
    );

    modport slave (
        input  m_tick, mem_rdata, instr_done, ie, if_flags,
        input  halt_req, ei_req, di_req, reti_req,
        output opcode, cb_prefix, isr_cmd, pc_inc, ime, halted
    );
endinterface

// File: rtl/gb_cpu_ime_ctrl.sv
// Interrupt master enable with the one-instruction EI delay.
// DI beats EI, RETI enables immediately, ISR entry clears everything.
module gb_cpu_ime_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic i_instr_end,
    input  logic i_ei_req,
    input  logic i_di_req,
    input  logic i_reti_req,
    input  logic i_isr_entry,
    output logic o_ime
);

    logic r_ime;
    logic r_ei_pending;
    logic w_ime_next;
    logic w_ei_pending_next;

    always_comb begin
        w_ime_next        = r_ime;
        w_ei_pending_next = r_ei_pending;
        if (i_isr_entry) begin
            w_ime_next        = 1'b0;
            w_ei_pending_next = 1'b0;
        end else if (i_instr_end) begin
            if (i_di_req) begin
                w_ime_next        = 1'b0;
                w_ei_pending_next = 1'b0;
            end else begin
                // A pending EI from the previous instruction matures here; a new EI re-arms.
                if (r_ei_pending || i_reti_req) begin
                    w_ime_next = 1'b1;
                end
                w_ei_pending_next = i_ei_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ime        <= 1'b0;
            r_ei_pending <= 1'b0;
        end else begin
            r_ime        <= w_ime_next;
            r_ei_pending <= w_ei_pending_next;
        end
    end

    assign o_ime = r_ime;

endmodule

// File: rtl/gb_cpu_ir_control.sv
// Instruction-register controller: fetches opcodes (with CB prefix), dispatches
// interrupts at fetch time and handles HALT. All state advances on m_tick only.
module gb_cpu_ir_control
    import gb_cpu_common_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    gb_cpu_ir_control_if.slave    bus
);

    ir_state_t  r_state;
    logic [7:0] r_opcode;
    logic       r_cb_prefix;
    logic       r_isr_cmd;
    logic       r_pc_inc;
    logic       r_halted;

    ir_state_t  w_state_next;
    logic [7:0] w_opcode_next;
    logic       w_cb_prefix_next;
    logic       w_isr_cmd_next;
    logic       w_pc_inc_next;
    logic       w_halted_next;
    logic       w_instr_end;
    logic       w_isr_entry;
    logic       w_irq;
    logic       w_ime;

    assign w_irq = irq_requested(bus.ie, bus.if_flags);

    always_comb begin
        w_state_next     = r_state;
        w_opcode_next    = r_opcode;
        w_cb_prefix_next = r_cb_prefix;
        w_isr_cmd_next   = r_isr_cmd;
        w_halted_next    = r_halted;
        w_pc_inc_next    = 1'b0;
        w_instr_end      = 1'b0;
        w_isr_entry      = 1'b0;
        if (bus.m_tick) begin
            unique case (r_state)
                FETCH: begin
                    if (w_ime && w_irq) begin
                        w_isr_cmd_next = 1'b1;
                        w_isr_entry    = 1'b1;
                        w_state_next   = EXEC;
                    end else begin
                        w_opcode_next    = bus.mem_rdata;
                        w_pc_inc_next    = 1'b1;
                        w_cb_prefix_next = 1'b0;
                        w_isr_cmd_next   = 1'b0;
                        w_state_next     = (bus.mem_rdata == CB_PREFIX_OPCODE) ? CB_FETCH : EXEC;
                    end
                end
                // No interrupt check here: the prefix and its operand byte are indivisible.
                CB_FETCH: begin
                    w_opcode_next    = bus.mem_rdata;
                    w_cb_prefix_next = 1'b1;
                    w_pc_inc_next    = 1'b1;
                    w_state_next     = EXEC;
                end
                EXEC: begin
                    if (bus.instr_done) begin
                        w_instr_end    = 1'b1;
                        w_isr_cmd_next = 1'b0;
                        if (bus.halt_req) begin
                            w_state_next  = HALT;
                            w_halted_next = 1'b1;
                        end else begin
                            w_state_next  = FETCH;
                        end
                    end
                end
                HALT: begin
                    // Wake-up ignores ime; dispatch is decided at the following fetch.
                    if (w_irq) begin
                        w_state_next  = FETCH;
                        w_halted_next = 1'b0;
                    end
                end
                default: w_state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_opcode    <= NOP_OPCODE;
            r_cb_prefix <= 1'b0;
            r_isr_cmd   <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_opcode    <= w_opcode_next;
            r_cb_prefix <= w_cb_prefix_next;
            r_isr_cmd   <= w_isr_cmd_next;
            r_pc_inc    <= w_pc_inc_next;
            r_halted    <= w_halted_next;
        end
    end

    gb_cpu_ime_ctrl u_ime_ctrl (
        .clk         (clk),
        .reset       (reset),
        .i_instr_end (w_instr_end),
        .i_ei_req    (bus.ei_req),
        .i_di_req    (bus.di_req),
        .i_reti_req  (bus.reti_req),
        .i_isr_entry (w_isr_entry),
        .o_ime       (w_ime)
    );

    assign bus.opcode    = r_opcode;
    assign bus.cb_prefix = r_cb_prefix;
    assign bus.isr_cmd   = r_isr_cmd;
    assign bus.pc_inc    = r_pc_inc;
    assign bus.ime       = w_ime;
    assign bus.halted    = r_halted;

endmodule
